// File: rtl/spi_flash_reader.sv
// Memory-mapped SPI flash reader: wakes the flash with 0xAB after reset, then
// issues 0x03 reads of one 32-bit word per CTRL start.
module spi_flash_reader #(
  parameter int unsigned DIVIDER     = 2,
  parameter int unsigned WAKE_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic        flash_clk,
  output logic        flash_csn,
  output logic        flash_io0_out,
  output logic        flash_io0_en,
  input  logic        flash_io1_in,
  output logic        flash_io1_out,
  output logic        flash_io1_en,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in
);

  typedef enum logic [2:0] {
    WAKE_CMD,
    WAKE_WAIT,
    IDLE,
    XFER,
    FINISH
  } state_t;

  localparam logic [7:0]  DIV_LAST  = 8'(DIVIDER - 1);
  localparam logic [31:0] WAKE_LAST = 32'(WAKE_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [31:0] wait_cnt;
  logic [63:0] tx_shift;
  logic [31:0] rx_shift;
  logic [23:0] flash_addr;
  logic [31:0] data_q;
  logic        done_q;

  logic [1:0]  reg_sel;
  logic        busy;
  logic        start;
  logic        addr_wr;
  logic        phase_end;
  logic        bit_rise;
  logic        bit_fall;
  logic        shifting;
  logic        unused_ok;

  assign reg_sel   = address_in[3:2];
  assign busy      = (state != IDLE);
  assign start     = sel_in && (reg_sel == 2'd1) && write_mask_in[0] && write_value_in[0];
  assign addr_wr   = sel_in && (reg_sel == 2'd0) && (state == IDLE);
  assign phase_end = (div_cnt == DIV_LAST);
  assign bit_rise  = phase_end && !flash_clk;
  assign bit_fall  = phase_end && flash_clk;
  assign shifting  = ((state == WAKE_CMD) && !flash_csn) || (state == XFER) || (state == FINISH);

  assign flash_io0_en  = 1'b1;
  assign flash_io1_out = 1'b0;
  assign flash_io1_en  = 1'b0;
  assign unused_ok     = ^{read_in, address_in[31:4], address_in[1:0],
                           write_mask_in[3], write_value_in[31:24]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAKE_CMD;
    end else begin
      state <= state_next;
    end
  end

  // FINISH covers the high half of the last bit so the final MISO sample lands
  // before csn rises and DATA is committed.
  always_comb begin
    state_next = state;
    unique case (state)
      WAKE_CMD:  if (!flash_csn && bit_fall && (bit_cnt == 6'd7)) state_next = WAKE_WAIT;
      WAKE_WAIT: if (wait_cnt == WAKE_LAST) state_next = IDLE;
      IDLE:      if (start) state_next = XFER;
      XFER:      if (bit_rise && (bit_cnt == 6'd63)) state_next = FINISH;
      FINISH:    if (bit_fall) state_next = IDLE;
      default:   state_next = WAKE_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flash_csn     <= 1'b1;
      flash_clk     <= 1'b0;
      flash_io0_out <= 1'b0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      wait_cnt      <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      flash_addr    <= '0;
      data_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      if (shifting) begin
        if (phase_end) begin
          div_cnt <= '0;
          if (!flash_clk) begin
            flash_clk <= 1'b1;
            rx_shift  <= {rx_shift[30:0], flash_io1_in};
          end else begin
            flash_clk     <= 1'b0;
            bit_cnt       <= bit_cnt + 6'd1;
            tx_shift      <= {tx_shift[62:0], 1'b0};
            flash_io0_out <= tx_shift[62];
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end

      case (state)
        WAKE_CMD: begin
          if (flash_csn) begin
            flash_csn     <= 1'b0;
            flash_clk     <= 1'b0;
            tx_shift      <= {8'hAB, 56'b0};
            flash_io0_out <= 1'b1;
            div_cnt       <= '0;
            bit_cnt       <= '0;
          end else if (state_next == WAKE_WAIT) begin
            flash_csn     <= 1'b1;
            flash_io0_out <= 1'b0;
            wait_cnt      <= '0;
          end
        end
        WAKE_WAIT: wait_cnt <= wait_cnt + 32'd1;
        IDLE: begin
          if (start) begin
            flash_csn     <= 1'b0;
            flash_clk     <= 1'b0;
            tx_shift      <= {8'h03, flash_addr, 32'b0};
            flash_io0_out <= 1'b0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            done_q        <= 1'b0;
          end else if (addr_wr) begin
            if (write_mask_in[0]) flash_addr[7:0]   <= write_value_in[7:0];
            if (write_mask_in[1]) flash_addr[15:8]  <= write_value_in[15:8];
            if (write_mask_in[2]) flash_addr[23:16] <= write_value_in[23:16];
          end
        end
        FINISH: begin
          // rx_shift holds the received bytes first-to-last; DATA is little-endian.
          if (state_next == IDLE) begin
            flash_csn     <= 1'b1;
            flash_io0_out <= 1'b0;
            done_q        <= 1'b1;
            data_q        <= {rx_shift[7:0], rx_shift[15:8], rx_shift[23:16], rx_shift[31:24]};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    read_value_out = '0;
    if (sel_in) begin
      case (reg_sel)
        2'd0:    read_value_out = {8'b0, flash_addr};
        2'd1:    read_value_out = {30'b0, done_q, busy};
        2'd2:    read_value_out = data_q;
        default: read_value_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (DIVIDER 2 and 1) each attached to a
// behavioural mode-0 flash; expected transfers are queued at start and checked at done.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [1:0]  sel;
  logic        read_strobe;
  logic [3:0]  wmask;
  logic [31:0] wvalue;
  logic [31:0] resp [2];
  int          cycle = 0;
  int          start_cycle;
  int          tests_run = 0;
  int          tests_failed = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] header;
    int          cycles;
  } exp_t;

  exp_t exp_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        sck;
    logic        csn;
    logic        mosi;
    logic        mosi_en;
    logic        io1_out;
    logic        io1_en;
    logic        miso = 1'b0;
    logic [31:0] rv;
    logic [63:0] log_sr = '0;
    logic [63:0] last_log = '0;
    int          bit_cnt = 0;
    int          last_cnt = 0;
    int          pulses = 0;
    logic        prev_csn = 1'b1;
    logic        prev_sck = 1'b0;

    spi_flash_reader #(.DIVIDER(g == 0 ? 2 : 1), .WAKE_CYCLES(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .flash_clk     (sck),
      .flash_csn     (csn),
      .flash_io0_out (mosi),
      .flash_io0_en  (mosi_en),
      .flash_io1_in  (miso),
      .flash_io1_out (io1_out),
      .flash_io1_en  (io1_en),
      .address_in    (address),
      .sel_in        (sel[g]),
      .read_in       (read_strobe),
      .read_value_out(rv),
      .write_mask_in (wmask),
      .write_value_in(wvalue)
    );

    // Mode-0 flash: capture MOSI on SCK rise, present MISO on SCK fall.
    always @(csn or sck) begin
      if (csn !== prev_csn) begin
        if (csn === 1'b0) begin
          bit_cnt = 0;
          log_sr  = '0;
          pulses++;
        end else begin
          last_log = log_sr;
          last_cnt = bit_cnt;
        end
      end else if ((sck !== prev_sck) && (csn === 1'b0)) begin
        if (sck === 1'b1) begin
          log_sr = {log_sr[62:0], mosi};
          bit_cnt++;
        end else if (bit_cnt >= 32 && bit_cnt < 64) begin
          miso = resp[g][31 - (bit_cnt - 32)];
        end
      end
      prev_csn = csn;
      prev_sck = sck;
    end
  end

  function automatic logic csnOf(input int unit);
    return (unit != 0) ? g_dut[1].csn : g_dut[0].csn;
  endfunction

  function automatic logic sckOf(input int unit);
    return (unit != 0) ? g_dut[1].sck : g_dut[0].sck;
  endfunction

  function automatic logic [63:0] lastLog(input int unit);
    return (unit != 0) ? g_dut[1].last_log : g_dut[0].last_log;
  endfunction

  function automatic int lastCnt(input int unit);
    return (unit != 0) ? g_dut[1].last_cnt : g_dut[0].last_cnt;
  endfunction

  function automatic int pulsesOf(input int unit);
    return (unit != 0) ? g_dut[1].pulses : g_dut[0].pulses;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic busWrite(input int unit, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] value);
    @(negedge clk);
    address   = addr;
    sel       = 2'b00;
    sel[unit] = 1'b1;
    wmask     = mask;
    wvalue    = value;
    @(negedge clk);
    sel   = 2'b00;
    wmask = 4'h0;
  endtask

  task automatic busRead(input int unit, input logic [31:0] addr, output logic [31:0] value);
    address     = addr;
    sel         = 2'b00;
    sel[unit]   = 1'b1;
    read_strobe = 1'b1;
    #1;
    value       = (unit != 0) ? g_dut[1].rv : g_dut[0].rv;
    sel         = 2'b00;
    read_strobe = 1'b0;
  endtask

  task automatic readCheck(input string tag, input int unit, input logic [31:0] addr,
                           input logic [31:0] expected);
    logic [31:0] v;
    busRead(unit, addr, v);
    checkOutput(tag, 64'(v), 64'(expected));
  endtask

  // Called on the falling edge right after the last reset edge.
  task automatic wakeCheck(input int unit, input string tag);
    logic [31:0] v;
    int          count = 0;
    bit          seen = 0;
    while (!seen && count < 500) begin
      @(posedge clk);
      #1;
      count++;
      busRead(unit, 32'h4, v);
      if (v[0] == 1'b0) seen = 1;
    end
    checkOutput({tag, " busy cycles"}, 64'(count), 64'd49);
    checkOutput({tag, " mosi byte"}, 64'(lastLog(unit) & 64'hFF), 64'hAB);
    checkOutput({tag, " sck pulses"}, 64'(lastCnt(unit)), 64'd8);
  endtask

  task automatic applyStimulus(input int unit, input logic [31:0] exp_data,
                               input logic [31:0] exp_header, input int exp_cycles);
    exp_t e;
    e.data   = exp_data;
    e.header = exp_header;
    e.cycles = exp_cycles;
    exp_q.push_back(e);
    busWrite(unit, 32'h4, 4'b0001, 32'h1);
    start_cycle = cycle;
  endtask

  task automatic waitDone(input int unit, input string tag);
    exp_t        e;
    logic [31:0] v;
    int          budget = 0;
    bit          seen = 0;
    while (!seen && budget < 2000) begin
      @(posedge clk);
      #1;
      budget++;
      busRead(unit, 32'h4, v);
      if (v[0] == 1'b0) seen = 1;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      checkOutput({tag, " timeout"}, 64'd0, 64'd1);
    end else begin
      checkOutput({tag, " busy cycles"}, 64'(cycle - start_cycle), 64'(e.cycles));
      checkOutput({tag, " done"}, 64'(v[1]), 64'd1);
      checkOutput({tag, " csn high"}, 64'(csnOf(unit)), 64'd1);
      checkOutput({tag, " sck low"}, 64'(sckOf(unit)), 64'd0);
      checkOutput({tag, " header"}, 64'(lastLog(unit) >> 32), 64'(e.header));
      checkOutput({tag, " bit count"}, 64'(lastCnt(unit)), 64'd64);
      readCheck({tag, " data"}, unit, 32'h8, e.data);
    end
  endtask

  initial begin
    int p;
    reset       = 1'b1;
    address     = '0;
    sel         = 2'b00;
    read_strobe = 1'b0;
    wmask       = 4'h0;
    wvalue      = '0;
    resp[0]     = '0;
    resp[1]     = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset csn", 64'(g_dut[0].csn), 64'd1);
    checkOutput("reset sck", 64'(g_dut[0].sck), 64'd0);
    checkOutput("reset mosi", 64'(g_dut[0].mosi), 64'd0);
    checkOutput("reset mosi_en", 64'(g_dut[0].mosi_en), 64'd1);
    checkOutput("reset io1 tie", 64'({g_dut[0].io1_out, g_dut[0].io1_en}), 64'd0);
    readCheck("reset addr", 0, 32'h0, 32'h0);
    readCheck("reset ctrl", 0, 32'h4, 32'h1);
    readCheck("reset data", 0, 32'h8, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wakeCheck(0, "wake");

    // Reset at bit 40 of the first transfer, while DATA still holds 0.
    resp[0] = 32'h5A5A5A5A;
    busWrite(0, 32'h0, 4'b0111, 32'h00123456);
    busWrite(0, 32'h4, 4'b0001, 32'h1);
    repeat (159) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst csn", 64'(g_dut[0].csn), 64'd1);
    checkOutput("midrst sck", 64'(g_dut[0].sck), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    readCheck("midrst data", 0, 32'h8, 32'h0);
    wakeCheck(0, "rewake");

    // Basic read.
    resp[0] = 32'hDEADBEEF;
    busWrite(0, 32'h0, 4'b0111, 32'h00123456);
    readCheck("addr write", 0, 32'h0, 32'h00123456);
    applyStimulus(0, 32'hEFBEADDE, 32'h03123456, 256);
    readCheck("xfer1 ctrl busy", 0, 32'h4, 32'h1);
    checkOutput("xfer1 csn low", 64'(g_dut[0].csn), 64'd0);
    waitDone(0, "xfer1");
    readCheck("xfer1 addr kept", 0, 32'h0, 32'h00123456);

    // Start and ADDR write while busy are ignored; max address sent verbatim.
    resp[0] = 32'h11223344;
    busWrite(0, 32'h0, 4'b0111, 32'h00FFFFFF);
    p = pulsesOf(0);
    applyStimulus(0, 32'h44332211, 32'h03FFFFFF, 256);
    readCheck("xfer2 done cleared", 0, 32'h4, 32'h1);
    repeat (20) @(negedge clk);
    busWrite(0, 32'h4, 4'b0001, 32'h1);
    busWrite(0, 32'h0, 4'b0111, 32'h0);
    readCheck("xfer2 data held", 0, 32'h8, 32'hEFBEADDE);
    waitDone(0, "xfer2");
    readCheck("xfer2 addr kept", 0, 32'h0, 32'h00FFFFFF);
    checkOutput("xfer2 one pulse", 64'(pulsesOf(0) - p), 64'd1);

    // Back-to-back start in the cycle busy falls.
    resp[0] = 32'hA5C30F81;
    applyStimulus(0, 32'h810FC3A5, 32'h03FFFFFF, 256);
    checkOutput("b2b csn low", 64'(g_dut[0].csn), 64'd0);
    waitDone(0, "b2b");
    repeat (10) @(negedge clk);
    checkOutput("b2b pulses", 64'(pulsesOf(0) - p), 64'd2);

    // Bus decode corner cases.
    for (int i = 0; i < 4; i++) begin
      address = 32'(i * 4);
      sel     = 2'b00;
      #1;
      checkOutput($sformatf("unsel read %0d", i), 64'(g_dut[0].rv), 64'd0);
    end
    readCheck("reserved read", 0, 32'hC, 32'h0);
    p = pulsesOf(0);
    busWrite(0, 32'h4, 4'b0010, 32'h1);
    repeat (5) @(negedge clk);
    readCheck("mask1 no start", 0, 32'h4, 32'h2);
    checkOutput("mask1 no pulse", 64'(pulsesOf(0) - p), 64'd0);
    busWrite(0, 32'h8, 4'hF, 32'h12345678);
    readCheck("data ro", 0, 32'h8, 32'h810FC3A5);
    busWrite(0, 32'hC, 4'hF, 32'h00000001);
    readCheck("reserved wr", 0, 32'h0, 32'h00FFFFFF);
    busWrite(0, 32'h0, 4'b1001, 32'hCC0000AA);
    readCheck("addr lane", 0, 32'h0, 32'h00FFFFAA);

    // DIVIDER=1 instance.
    resp[1] = 32'h00FF0FF0;
    busWrite(1, 32'h0, 4'b0111, 32'h00000ABC);
    applyStimulus(1, 32'hF00FFF00, 32'h03000ABC, 128);
    waitDone(1, "div1");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001: Parameter DIVIDER, default 2, clk cycles per flash_clk half-period (legal values 1 to 255).
REQ-002: Parameter WAKE_CYCLES, default 1024, clk cycles waited after the release-power-down command.
REQ-003: clk  input  1  system clock; all logic on the posedge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: flash_clk  output  1  SPI SCK, mode 0.
REQ-006: flash_csn  output  1  SPI chip select, active low.
REQ-007: flash_io0_out  output  1  MOSI data.
REQ-008: flash_io0_en  output  1  MOSI output enable.
REQ-009: flash_io1_in  input  1  MISO data.
REQ-010: flash_io1_out  output  1  unused; tied to 0.
REQ-011: flash_io1_en  output  1  tied to 0.
REQ-012: address_in  input  32  memory bus byte address.
REQ-013: sel_in  input  1  block selected by the top-level decoder.
REQ-014: read_in  input  1  bus read strobe; no side effects on read.
REQ-015: read_value_out  output  32  read data; 0 when sel_in is low (OR-combined bus).
REQ-016: write_mask_in  input  4  byte write enables.
REQ-017: write_value_in  input  32  write data.

Function
REQ-018: Register select is address_in[3:2]: 0 = ADDR, 1 = CTRL, 2 = DATA, 3 = reserved.
REQ-019: ADDR is a 24-bit flash byte address; byte lanes 0-2 write under their mask bits; reads return {8'b0, ADDR}.
REQ-020: CTRL read returns {30'b0, done, busy}; a write with write_mask_in[0]=1 and write_value_in[0]=1 is a start.
REQ-021: DATA is read-only; writes to DATA and to reserved offset 3 are ignored; offset 3 reads 0.
REQ-022: read_value_out is combinational from sel_in, address_in and the registers; it carries no added latency.
REQ-023: States are WAKE_CMD, WAKE_WAIT, IDLE, XFER and FINISH.
REQ-024: WAKE_CMD: after reset, csn goes low and sends the 8-bit command 0xAB; csn then rises and the block enters WAKE_WAIT.
REQ-025: WAKE_WAIT: waits WAKE_CYCLES cycles, then goes to IDLE; busy=1 in WAKE_CMD, WAKE_WAIT, XFER and FINISH.
REQ-026: A start in IDLE, sampled at edge N, sets busy, clears done, drives csn low, and sets flash_io0_out to the first bit, all from edge N.
REQ-027: XFER shifts 64 bits: command 0x03, then ADDR[23:0] MSB first, then 32 MISO bits.
REQ-028: Bit timing: each bit spans 2*DIVIDER cycles; flash_clk is low for the first DIVIDER cycles and high for the second DIVIDER cycles.
REQ-029: MOSI changes only while flash_clk is low; flash_io1_in is sampled on the edge where flash_clk goes high.
REQ-030: Received bytes arrive MSB first within each byte; the first byte goes to DATA[7:0], the fourth to DATA[31:24] (little-endian).
REQ-031: FINISH: at edge N+128*DIVIDER, flash_clk is low, csn is high, DATA is updated, busy=0, done=1, and the block returns to IDLE.
REQ-032: Back-to-back: a start written in the cycle busy falls is accepted; csn stays high for at least 1 cycle between transfers.
REQ-033: A start while busy=1 is ignored; ADDR writes while busy=1 are ignored; DATA holds its old value until FINISH.
REQ-034: Start and ADDR write in the same cycle are impossible, since they use distinct offsets.
REQ-035: ADDR is not changed by transfers; an address of 0xFFFFFF is sent verbatim, and flash-side wrap is not the block's concern.

Reset
REQ-036: Reset values: flash_csn=1, flash_clk=0, flash_io0_out=0, flash_io0_en=1, ADDR=0, DATA=0, done=0, busy=1, state=WAKE_CMD.
REQ-037: Reset asserted mid-transfer forces csn high and clk low on the next edge, discards the partial data, and restarts from WAKE_CMD.

Verification
REQ-038: Reset, DIVIDER=2, WAKE_CYCLES=16 -> MOSI carries 0xAB over 8 SCK pulses; busy stays 1 until 32+1+16 cycles later, then 0.
REQ-039: ADDR=0x123456, start, flash model returns 0xDE,0xAD,0xBE,0xEF -> MOSI bits 03 12 34 56; busy for 256 cycles; DATA=0xEFBEADDE; done=1.
REQ-040: Start while busy, plus ADDR write of 0x000000 mid-transfer -> only one csn low pulse; transfer uses the original ADDR.
REQ-041: Reset at bit 40 of a transfer -> csn high next cycle; DATA stays at its prior value; a wake sequence follows.
REQ-042: sel_in=0 with any address -> read_value_out=0; offset 0xC with sel_in=1 -> 0; CTRL write with mask 4'b0010 and value 1 -> no start.
REQ-043: DIVIDER=1 with a MISO stream 0x00,0xFF,0x0F,0xF0 -> DATA=0xF00FFF00; busy for 128 cycles.
